// File: rtl/mem_stage_axi_lsu.sv
// MEM-stage load/store unit: turns MemReadM/MemWriteM into single AXI4-Lite transactions and stalls the pipe until done.
// Optional MISALIGN_CHECK_EN: misaligned H/W accesses fault in one cycle without touching the bus.
module mem_stage_axi_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              MemErrM,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d, err_q, err_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;

  logic              misalign;
  logic [31:0]       st_data;
  logic [3:0]        st_strb;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;

  always_comb begin
`ifdef MISALIGN_CHECK_EN
    misalign = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
               ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  // Stores drive every lane with the replicated value; wstrb picks the real one.
  always_comb begin
    case (Funct3M[1:0])
      2'b00: begin
        st_data = {4{WriteDataM[7:0]}};
        st_strb = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        st_data = {2{WriteDataM[15:0]}};
        st_strb = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      default: begin
        st_data = WriteDataM;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = m_rdata[7:0];
      2'd1:    ld_byte = m_rdata[15:8];
      2'd2:    ld_byte = m_rdata[23:16];
      default: ld_byte = m_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = m_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_d     = err_q;
    lane_d    = lane_q;
    f3_d      = f3_q;
    case (state_q)
      IDLE: begin
        if (MemReadM || MemWriteM) begin
          lane_d = ALUResultM[1:0];
          f3_d   = Funct3M;
          err_d  = 1'b0;
          if (misalign) begin
            err_d   = 1'b1;
            state_d = DONE;
            if (MemReadM) rdata_d = 32'h0;
          end else if (MemWriteM) begin
            awaddr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
            wdata_d   = st_data;
            wstrb_d   = st_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WR: begin
        // AW and W retire independently; leave only when neither is pending.
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d  = wvalid_q && !m_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (m_bvalid) begin
          bready_d = 1'b0;
          err_d    = (m_bresp != 2'b00);
          state_d  = DONE;
        end
      end
      RADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_rvalid) begin
          rready_d = 1'b0;
          err_d    = (m_rresp != 2'b00);
          rdata_d  = (m_rresp != 2'b00) ? 32'h0 : ld_ext;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      rdata_q   <= 32'h0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
      lane_q    <= 2'b00;
      f3_q      <= 3'b000;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      err_q     <= err_d;
      lane_q    <= lane_d;
      f3_q      <= f3_d;
    end
  end

  // A non-memory instruction in IDLE never stalls.
  assign StallM    = (state_q == IDLE) ? (MemReadM || MemWriteM) : (state_q != DONE);
  assign MemErrM   = (state_q == DONE) && err_q;
  assign ReadDataM = rdata_q;
  assign m_awaddr  = awaddr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = araddr_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

endmodule

// File: tb/tb_mem_stage_axi_lsu.sv
// Bench for mem_stage_axi_lsu: directed vector table, reset-mid-read sequence, and random accesses
// against a behavioural load/store model with a delay-configurable AXI4-Lite slave.
module tb_mem_stage_axi_lsu;

  localparam int MAXW = 300;
`ifdef MISALIGN_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MemErrM;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  always #5 clk = ~clk;

  mem_stage_axi_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MemErrM(MemErrM),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int failures = 0;

  // Slave configuration and observations
  int          aw_dly, w_dly, ar_dly, r_dly, b_dly;
  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  int          aw_hs, w_hs, ar_hs, hold_err;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // AXI4-Lite slave: readies/responses change only on the falling edge, so each rising
  // edge sees exactly the values snapshotted at the end of the previous falling edge.
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic sn_aw_hs, sn_w_hs, sn_ar_hs, sn_aw_hold, sn_w_hold, sn_ar_hold;
    logic [31:0] sn_awaddr, sn_wdata, sn_araddr;
    logic [3:0]  sn_wstrb;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    sn_aw_hs = 0; sn_w_hs = 0; sn_ar_hs = 0; sn_aw_hold = 0; sn_w_hold = 0; sn_ar_hold = 0;
    sn_awaddr = 0; sn_wdata = 0; sn_araddr = 0; sn_wstrb = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        sn_aw_hs = 0; sn_w_hs = 0; sn_ar_hs = 0;
        sn_aw_hold = 0; sn_w_hold = 0; sn_ar_hold = 0;
        continue;
      end
      if (sn_aw_hs) begin aw_hs++; cap_awaddr = sn_awaddr; end
      if (sn_w_hs)  begin w_hs++; cap_wdata = sn_wdata; cap_wstrb = sn_wstrb; end
      if (sn_ar_hs) begin ar_hs++; cap_araddr = sn_araddr; end
      if (sn_aw_hold && !(m_awvalid === 1'b1 && m_awaddr === sn_awaddr)) hold_err++;
      if (sn_w_hold && !(m_wvalid === 1'b1 && m_wdata === sn_wdata && m_wstrb === sn_wstrb)) hold_err++;
      if (sn_ar_hold && !(m_arvalid === 1'b1 && m_araddr === sn_araddr)) hold_err++;

      if (m_awvalid) begin
        if (aw_cnt >= aw_dly) m_awready = 1; else begin m_awready = 0; aw_cnt++; end
      end else begin m_awready = 0; aw_cnt = 0; end
      if (m_wvalid) begin
        if (w_cnt >= w_dly) m_wready = 1; else begin m_wready = 0; w_cnt++; end
      end else begin m_wready = 0; w_cnt = 0; end
      if (m_arvalid) begin
        if (ar_cnt >= ar_dly) m_arready = 1; else begin m_arready = 0; ar_cnt++; end
      end else begin m_arready = 0; ar_cnt = 0; end
      if (m_bready) begin
        if (b_cnt >= b_dly) begin m_bvalid = 1; m_bresp = s_resp; end
        else begin m_bvalid = 0; m_bresp = 0; b_cnt++; end
      end else begin m_bvalid = 0; m_bresp = 0; b_cnt = 0; end
      if (m_rready) begin
        if (r_cnt >= r_dly) begin m_rvalid = 1; m_rresp = s_resp; m_rdata = s_rdata; end
        else begin m_rvalid = 0; m_rresp = 0; m_rdata = 0; r_cnt++; end
      end else begin m_rvalid = 0; m_rresp = 0; m_rdata = 0; r_cnt = 0; end

      sn_aw_hs = m_awvalid && m_awready; sn_aw_hold = m_awvalid && !m_awready; sn_awaddr = m_awaddr;
      sn_w_hs  = m_wvalid && m_wready;   sn_w_hold  = m_wvalid && !m_wready;
      sn_wdata = m_wdata; sn_wstrb = m_wstrb;
      sn_ar_hs = m_arvalid && m_arready; sn_ar_hold = m_arvalid && !m_arready; sn_araddr = m_araddr;
    end
  end

  // One pipeline access: present it, wait out the stall, check the DONE cycle and the cycle after.
  task automatic run_txn(input string name, input bit ld, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [1:0] resp, input int awd, input int wd, input int ard,
                         input int rd, input int bd, input logic [31:0] exp_rd, input bit exp_err,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input int exp_stall, input bit exp_bus);
    int stall;
    @(negedge clk);
    aw_dly = awd; w_dly = wd; ar_dly = ard; r_dly = rd; b_dly = bd;
    s_rdata = rdata; s_resp = resp;
    aw_hs = 0; w_hs = 0; ar_hs = 0; hold_err = 0;
    MemReadM = ld; MemWriteM = !ld; Funct3M = f3; ALUResultM = addr; WriteDataM = wdata;
    #1;
    stall = 0;
    while (StallM === 1'b1 && stall < MAXW) begin
      stall++;
      @(negedge clk);
      #1;
    end
    if (stall >= MAXW) begin
      checks++; failures++;
      $display("FAIL %s.timeout actual=stall_cycles>=%0d required=release", name, MAXW);
    end
    chk({name, ".ReadDataM"}, ReadDataM, exp_rd);
    chk({name, ".MemErrM"}, 32'(MemErrM), 32'(exp_err));
    chk({name, ".stall_cycles"}, 32'(stall), 32'(exp_stall));
    if (exp_bus && ld) begin
      chk({name, ".ar_handshakes"}, 32'(ar_hs), 32'd1);
      chk({name, ".araddr"}, cap_araddr, {addr[31:2], 2'b00});
    end else if (exp_bus) begin
      chk({name, ".aw_handshakes"}, 32'(aw_hs), 32'd1);
      chk({name, ".w_handshakes"}, 32'(w_hs), 32'd1);
      chk({name, ".awaddr"}, cap_awaddr, {addr[31:2], 2'b00});
      chk({name, ".wstrb"}, 32'(cap_wstrb), 32'(exp_strb));
      chk({name, ".wdata"}, cap_wdata, exp_wdata);
    end
    chk({name, ".total_handshakes"}, 32'(aw_hs + w_hs + ar_hs), exp_bus ? (ld ? 32'd1 : 32'd2) : 32'd0);
    chk({name, ".hold_violations"}, 32'(hold_err), 32'd0);
    @(negedge clk);
    MemReadM = 0; MemWriteM = 0;
    #1;
    chk({name, ".MemErrM_after"}, 32'(MemErrM), 32'd0);
    chk({name, ".StallM_after"}, 32'(StallM), 32'd0);
    chk({name, ".ReadDataM_held"}, ReadDataM, exp_rd);
    $display("txn %s ld=%0d f3=%0d addr=0x%08h rd=0x%08h err=%0d stall=%0d", name, ld, f3, addr,
             ReadDataM, exp_err, stall);
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  typedef struct {
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  resp;
    int          awd, wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          exp_stall;
    bit          exp_bus;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ld_f3 [5];
    logic [31:0] model_rd, e_wdata;
    logic [3:0]  e_strb;
    bit          ld, misal, e_err, e_bus;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  resp;
    int          awd, wd, ard, rd, bd, e_stall, n;

    reset = 0; MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 0; s_rdata = 0; s_resp = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; hold_err = 0;
    cap_awaddr = 0; cap_wdata = 0; cap_araddr = 0; cap_wstrb = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset.StallM", 32'(StallM), 32'd0);
    chk("reset.ReadDataM", ReadDataM, 32'd0);
    chk("reset.MemErrM", 32'(MemErrM), 32'd0);
    chk("reset.valids_readies", {27'd0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 32'd0);
    chk("reset.awaddr", m_awaddr, 32'd0);
    chk("reset.araddr", m_araddr, 32'd0);
    chk("reset.wdata", m_wdata, 32'd0);
    chk("reset.wstrb", 32'(m_wstrb), 32'd0);
    @(negedge clk);
    reset = 1;

    //          ld f3      addr          wdata         rdata         rsp  awd wd exp_rd        err strb     exp_wdata     stall bus
    vecs[0]  = '{1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2'b00, 0, 0, 32'hDEADBEEF, 0, 4'h0, 32'h0, 3, 1};
    vecs[1]  = '{1, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 2'b00, 0, 0, 32'hFFFFFF80, 0, 4'h0, 32'h0, 3, 1};
    vecs[2]  = '{1, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 2'b00, 0, 0, 32'h00000080, 0, 4'h0, 32'h0, 3, 1};
    vecs[3]  = '{1, 3'b101, 32'h102, 32'h0, 32'h80FFFFFF, 2'b00, 0, 0, 32'h000080FF, 0, 4'h0, 32'h0, 3, 1};
    vecs[4]  = '{1, 3'b001, 32'h102, 32'h0, 32'h80FFFFFF, 2'b00, 0, 0, 32'hFFFF80FF, 0, 4'h0, 32'h0, 3, 1};
    vecs[5]  = '{0, 3'b001, 32'h206, 32'h1234ABCD, 32'h0, 2'b00, 3, 0, 32'hFFFF80FF, 0, 4'b1100, 32'hABCDABCD, 6, 1};
    vecs[6]  = '{0, 3'b000, 32'h301, 32'h000000A5, 32'h0, 2'b00, 0, 0, 32'hFFFF80FF, 0, 4'b0010, 32'hA5A5A5A5, 3, 1};
    vecs[7]  = '{0, 3'b010, 32'h400, 32'h01234567, 32'h0, 2'b00, 0, 2, 32'hFFFF80FF, 0, 4'b1111, 32'h01234567, 5, 1};
    vecs[8]  = '{1, 3'b010, 32'h100, 32'h0, 32'h12345678, 2'b10, 0, 0, 32'h0, 1, 4'h0, 32'h0, 3, 1};
    vecs[9]  = '{0, 3'b010, 32'h404, 32'h55AA55AA, 32'h0, 2'b11, 0, 0, 32'h0, 1, 4'b1111, 32'h55AA55AA, 3, 1};
    vecs[10] = '{1, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 2'b00, 0, 0, MCHK ? 32'h0 : 32'hCAFEF00D,
                 MCHK, 4'h0, 32'h0, MCHK ? 1 : 3, !MCHK};
    vecs[11] = '{1, 3'b001, 32'h101, 32'h0, 32'h11228344, 2'b00, 0, 0, MCHK ? 32'h0 : 32'hFFFF8344,
                 MCHK, 4'h0, 32'h0, MCHK ? 1 : 3, !MCHK};

    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].ld, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              vecs[i].rdata, vecs[i].resp, vecs[i].awd, vecs[i].wd, 0, 0, 0, vecs[i].exp_rd,
              vecs[i].exp_err, vecs[i].exp_strb, vecs[i].exp_wdata, vecs[i].exp_stall,
              vecs[i].exp_bus);
    end

    // Reset asserted while the read data phase is still waiting on the slave
    @(negedge clk);
    ar_dly = 0; r_dly = 20; s_rdata = 32'h77777777; s_resp = 0;
    MemReadM = 1; MemWriteM = 0; Funct3M = 3'b010; ALUResultM = 32'h500;
    n = 0;
    while (m_rready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid.reached_rdata", 32'(m_rready), 32'd1);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_mid.valids_readies", {27'd0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 32'd0);
    chk("rst_mid.StallM_load_held", 32'(StallM), 32'd1);
    chk("rst_mid.ReadDataM", ReadDataM, 32'd0);
    chk("rst_mid.MemErrM", 32'(MemErrM), 32'd0);
    MemReadM = 0;
    #1;
    chk("rst_mid.StallM_idle", 32'(StallM), 32'd0);
    $display("txn rst_mid araddr=0x%08h rd=0x%08h", m_araddr, ReadDataM);
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    model_rd = 32'h0;

    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    for (int t = 0; t < 60; t++) begin
      ld    = bit'($urandom_range(0, 1));
      f3    = ld ? ld_f3[$urandom_range(0, 4)] : ld_f3[$urandom_range(0, 2)];
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); ard = $urandom_range(0, 3);
      rd  = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      misal = MCHK && (((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 0)));
      e_strb = 4'h0; e_wdata = 32'h0;
      if (misal) begin
        e_err = 1; e_bus = 0; e_stall = 1;
        if (ld) model_rd = 32'h0;
      end else if (ld) begin
        e_err = (resp != 0); e_bus = 1; e_stall = 3 + ard + rd;
        model_rd = e_err ? 32'h0 : ref_load(f3, addr, rdata);
      end else begin
        e_err = (resp != 0); e_bus = 1; e_stall = 3 + ((awd > wd) ? awd : wd) + bd;
        case (f3)
          3'b000: begin
            e_wdata = (wdata & 32'hFF) * 32'h01010101;
            e_strb  = 4'(1 << addr[1:0]);
          end
          3'b001: begin
            e_wdata = (wdata & 32'hFFFF) * 32'h00010001;
            e_strb  = 4'(3 << (2 * addr[1]));
          end
          default: begin
            e_wdata = wdata;
            e_strb  = 4'hF;
          end
        endcase
      end
      run_txn($sformatf("rnd%0d", t), ld, f3, addr, wdata, rdata, resp, awd, wd, ard, rd, bd,
              model_rd, e_err, e_strb, e_wdata, e_stall, e_bus);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
